cpu_run_controller: RTL and testbench
=====================================

// Module: cpu_run_controller
// PURPOSE
//  Upstream sequencer for the pipelined CPU core: debounces the board start button and latches the encrypt/decrypt mode.
//  Holds the core in reset, releases it, and gates the core's cycle-counter enable.
//  Detects the HALT opcode at fetch, waits for the pipeline to drain, then reports done/timeout with a cycle count and the halt PC.
// PARAMETERS
//  PC_WIDTH         16        width of pc_in / halt_pc
//  INSTR_WIDTH      20        width of instr_fetch_in; opcode = [INSTR_WIDTH-1 -: 5]
//  HALT_OPCODE      5'b11111  opcode that ends a program
//  DEBOUNCE_CYCLES  50000     stable cycles before the debounced level changes
//  RESET_HOLD       4         cycles cpu_reset stays high in ARM
//  DRAIN_CYCLES     5         cycles run after HALT is seen (pipeline depth)
//  MAX_CYCLES       2**24     watchdog limit on run_cycles
// PORTS
//  clk             in   1            system clock
//  reset           in   1            synchronous, active-high
//  start_btn       in   1            raw push button, asynchronous to clk
//  mode_sel        in   1            encrypt(0)/decrypt(1) switch
//  pc_in           in   PC_WIDTH     core PC (mux output, fetch stage)
//  instr_fetch_in  in   INSTR_WIDTH  core fetched instruction (ROM q, 1-cycle latency)
//  cpu_reset       out  1            reset to core, active-high
//  cpu_mode        out  1            latched mode, drives the core's encrypt_decrypt input
//  counter_enable  out  1            drives the core's enable_counter input
//  busy            out  1            high in ARM/RUN/DRAIN
//  done            out  1            high in DONE
//  timeout         out  1            high in TIMEOUT
//  run_cycles      out  32           cycles with counter_enable high this run
//  halt_pc         out  PC_WIDTH     PC of the HALT instruction
// BEHAVIOUR
//  Reset values:
//   cpu_reset=1; cpu_mode, counter_enable, busy, done, timeout = 0; run_cycles=0; halt_pc=0; state=IDLE.
//  start_btn path:
//   2-FF synchroniser, then debouncer: level updates after DEBOUNCE_CYCLES consecutive equal samples.
//   start_pulse = 1-cycle rising edge of the debounced level.
//  IDLE:
//   cpu_reset=1. On start_pulse: ARM, latch cpu_mode<=mode_sel, clear run_cycles and halt_pc.
//  ARM:
//   cpu_reset=1 for exactly RESET_HOLD cycles, then RUN.
//  RUN:
//   cpu_reset=0; counter_enable=1; run_cycles+=1 every cycle.
//   Opcode compare is masked on the first RUN cycle (ROM latency).
//   Opcode==HALT_OPCODE: DRAIN, load drain count, halt_pc<=pc_in registered one cycle earlier.
//   run_cycles==MAX_CYCLES-1 in this cycle: TIMEOUT.
//   HALT and limit in the same cycle: HALT wins.
//  DRAIN:
//   counter_enable=1, run_cycles counts; further HALTs ignored.
//   After DRAIN_CYCLES cycles: DONE.
//  DONE:
//   cpu_reset=0 so register/RAM state stays observable; counter_enable=0; run_cycles and halt_pc frozen.
//  TIMEOUT:
//   cpu_reset=1, counter_enable=0, run_cycles frozen at MAX_CYCLES.
//  Re-run:
//   start_pulse in DONE or TIMEOUT goes to ARM with the same clear/latch as IDLE.
//   start_pulse in ARM/RUN/DRAIN is ignored.
//   mode_sel changes are only sampled on start_pulse.
//  Reset mid-operation:
//   next edge forces IDLE and all reset values, whatever the state.
//   The debouncer also resets, so a held button needs DEBOUNCE_CYCLES to re-qualify after reset is released.
//  run_cycles:
//   saturates at 32'hFFFF_FFFF; never wraps.
// STRUCTURE
//  cpu_ctrl_pkg:
//   run_state_t enum {IDLE, ARM, RUN, DRAIN, DONE, TIMEOUT}; OPCODE_W=5; HALT_OPCODE default.
//  Sub-module button_debouncer (sync + stable counter + rising-edge pulse):
//   params DEBOUNCE_CYCLES; ports clk, reset, btn_raw, level, rise_pulse.
//  The top-level FSM, counters and capture registers live in this module.
// TESTING (DEBOUNCE_CYCLES=4, RESET_HOLD=3, DRAIN_CYCLES=5, MAX_CYCLES=64)
//  1 reset held 3 cycles -> cpu_reset=1, every other output 0, state IDLE.
//  2 start_btn toggling every 2 cycles for 20 cycles, then low -> no ARM.
//    Held high 10 cycles -> exactly one ARM entry.
//  3 mode_sel=1, start, HALT on 20th RUN cycle at previous pc=16'h0013 ->
//    cpu_reset low exactly 25 cycles before DONE, run_cycles=25, halt_pc=16'h0013, cpu_mode=1.
//  4 start, never HALT -> timeout=1 after 64 RUN cycles, run_cycles=64, cpu_reset=1, counter_enable=0.
//  5 in DONE, mode_sel=0, start -> ARM, run_cycles=0, cpu_mode=0, 3 cycles cpu_reset=1, then RUN.
//  6 reset asserted on the 7th RUN cycle -> IDLE next edge, cpu_reset=1, run_cycles=0; start during RUN ignored.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
// Holds the run-state encoding, the opcode field width and the default HALT opcode.
// Imported by the controller top level.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        RUN,
        DRAIN,
        DONE,
        TIMEOUT
    } run_state_t;

    localparam int OPCODE_W = 5;
    localparam logic [OPCODE_W-1:0] DEF_HALT_OPCODE = 5'b11111;

endpackage

// File: rtl/button_debouncer.sv
// Start-button conditioner: 2-FF synchroniser, stability counter, rising-edge pulse.
// Ports: clk, reset (sync, active-high), btn_raw (async raw button),
//        level (debounced level), rise_pulse (1 cycle on a debounced 0->1).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic rise_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] stable_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            level      <= 1'b0;
            level_q    <= 1'b0;
            stable_cnt <= '0;
        end else begin
            sync1   <= btn_raw;
            sync2   <= sync1;
            level_q <= level;
            // Count consecutive samples that disagree with the current level;
            // any agreeing sample restarts the count.
            if (sync2 == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level      <= sync2;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + CNT_W'(1);
            end
        end
    end

    assign rise_pulse = level & ~level_q;

endmodule

// File: rtl/cpu_run_controller.sv
// Run sequencer for the pipelined CPU core: start button -> core reset/release -> HALT drain -> done/timeout.
// Ports: clk, reset (sync, active-high), start_btn, mode_sel, pc_in, instr_fetch_in in;
//        cpu_reset, cpu_mode, counter_enable, busy, done, timeout, run_cycles, halt_pc out.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int                   PC_WIDTH        = 16,
    parameter int                   INSTR_WIDTH     = 20,
    parameter logic [OPCODE_W-1:0]  HALT_OPCODE     = DEF_HALT_OPCODE,
    parameter int                   DEBOUNCE_CYCLES = 50000,
    parameter int                   RESET_HOLD      = 4,
    parameter int                   DRAIN_CYCLES    = 5,
    parameter int                   MAX_CYCLES      = 2**24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_btn,
    input  logic                   mode_sel,
    input  logic [PC_WIDTH-1:0]    pc_in,
    input  logic [INSTR_WIDTH-1:0] instr_fetch_in,
    output logic                   cpu_reset,
    output logic                   cpu_mode,
    output logic                   counter_enable,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout,
    output logic [31:0]            run_cycles,
    output logic [PC_WIDTH-1:0]    halt_pc
);

    localparam int ARM_W   = $clog2(RESET_HOLD + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    run_state_t           state;
    run_state_t           state_nxt;
    logic                 start_pulse;
    logic                 btn_level;
    logic                 start_accept;
    logic                 halt_seen;
    logic                 at_limit;
    logic                 arm_last;
    logic                 drain_last;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [ARM_W-1:0]     arm_cnt;
    logic [DRAIN_W-1:0]   drain_cnt;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (start_btn),
        .level      (btn_level),
        .rise_pulse (start_pulse)
    );

    // Only the opcode field and the edge pulse matter here.
    logic unused_ok;
    assign unused_ok = &{1'b0, btn_level, instr_fetch_in[INSTR_WIDTH-OPCODE_W-1:0]};

    assign start_accept = start_pulse &&
                          (state == IDLE || state == DONE || state == TIMEOUT);
    // run_cycles is still zero only on the first RUN cycle, when the ROM output
    // does not yet correspond to a fetched PC, so the compare is masked there.
    assign halt_seen  = (instr_fetch_in[INSTR_WIDTH-1 -: OPCODE_W] == HALT_OPCODE) &&
                        (run_cycles != 32'd0);
    assign at_limit   = (run_cycles == 32'(MAX_CYCLES - 1));
    assign arm_last   = (arm_cnt == ARM_W'(RESET_HOLD - 1));
    assign drain_last = (drain_cnt == DRAIN_W'(DRAIN_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE, TIMEOUT: if (start_pulse) state_nxt = ARM;
            ARM:                 if (arm_last)    state_nxt = RUN;
            RUN: begin
                // HALT takes priority over the watchdog in the same cycle.
                if (halt_seen)     state_nxt = DRAIN;
                else if (at_limit) state_nxt = TIMEOUT;
            end
            DRAIN:               if (drain_last)  state_nxt = DONE;
            default:             state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        cpu_reset      = 1'b1;
        counter_enable = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        timeout        = 1'b0;
        case (state)
            ARM:     busy = 1'b1;
            RUN, DRAIN: begin
                cpu_reset      = 1'b0;
                counter_enable = 1'b1;
                busy           = 1'b1;
            end
            // Core stays out of reset so its register/RAM contents can be inspected.
            DONE: begin
                cpu_reset = 1'b0;
                done      = 1'b1;
            end
            TIMEOUT: timeout = 1'b1;
            default: cpu_reset = 1'b1;
        endcase
    end

    // Counters and capture registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_mode   <= 1'b0;
            run_cycles <= 32'd0;
            halt_pc    <= '0;
            pc_q       <= '0;
            arm_cnt    <= '0;
            drain_cnt  <= '0;
        end else begin
            // pc_q lines up with instr_fetch_in, which lags the PC by one cycle.
            pc_q <= pc_in;

            if (start_accept) begin
                cpu_mode   <= mode_sel;
                run_cycles <= 32'd0;
                halt_pc    <= '0;
            end else if ((state == RUN || state == DRAIN) && run_cycles != 32'hFFFF_FFFF) begin
                run_cycles <= run_cycles + 32'd1;
            end

            if (state == RUN && halt_seen) halt_pc <= pc_q;

            if (state == ARM) arm_cnt <= arm_cnt + ARM_W'(1);
            else              arm_cnt <= '0;

            if (state == DRAIN) drain_cnt <= drain_cnt + DRAIN_W'(1);
            else                drain_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Self-checking bench for cpu_run_controller with short debounce/hold/drain/watchdog settings.
// Table of complete runs plus directed sequences for bounce, reset mid-run and ignored starts.
module tb_cpu_run_controller;
    import cpu_ctrl_pkg::*;

    localparam int PCW = 16;
    localparam int IW  = 20;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_btn;
    logic           mode_sel;
    logic [PCW-1:0] pc_in;
    logic [IW-1:0]  instr_fetch_in;
    logic           cpu_reset;
    logic           cpu_mode;
    logic           counter_enable;
    logic           busy;
    logic           done;
    logic           timeout;
    logic [31:0]    run_cycles;
    logic [PCW-1:0] halt_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cpu_run_controller #(
        .PC_WIDTH        (PCW),
        .INSTR_WIDTH     (IW),
        .HALT_OPCODE     (5'b11111),
        .DEBOUNCE_CYCLES (4),
        .RESET_HOLD      (3),
        .DRAIN_CYCLES    (5),
        .MAX_CYCLES      (64)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start_btn      (start_btn),
        .mode_sel       (mode_sel),
        .pc_in          (pc_in),
        .instr_fetch_in (instr_fetch_in),
        .cpu_reset      (cpu_reset),
        .cpu_mode       (cpu_mode),
        .counter_enable (counter_enable),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .run_cycles     (run_cycles),
        .halt_pc        (halt_pc)
    );

    typedef struct {
        logic        mode;
        int          halt_at;      // RUN cycle carrying HALT; 0 = never
        logic [15:0] prev_pc;      // PC driven on the cycle before HALT
        logic        exp_done;
        logic        exp_timeout;
        logic [31:0] exp_cycles;
        logic [15:0] exp_halt_pc;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        pc_in          = '0;
        instr_fetch_in = '0;
    endtask

    // Behaves like the core during RUN cycle k (1-based).
    task automatic drive_core(input int k, input int halt_at, input logic [15:0] prev_pc);
        logic halt_now;
        halt_now = (k == halt_at) || (halt_at > 1 && k > halt_at);
        pc_in = (k == halt_at - 1) ? prev_pc : (16'h4000 | 16'(k));
        instr_fetch_in = halt_now ? {5'b11111, 15'h0} : {5'b00001, 15'(k)};
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  k;
        int  armc;
        int  n;
        bit  seen_busy;
        bit  ended;
        string tag;
        tag = $sformatf("v%0d", idx);
        start_btn = 1'b0;
        drive_idle();
        repeat (8) @(negedge clk);
        mode_sel  = v.mode;
        start_btn = 1'b1;
        k = 0; armc = 0; n = 0; seen_busy = 0; ended = 0;
        while (n < 250 && !ended) begin
            @(negedge clk);
            n++;
            if (busy && !seen_busy) begin
                seen_busy = 1;
                start_btn = 1'b0;
                check({tag, "_clr_cycles"}, run_cycles, 32'd0);
                check({tag, "_clr_halt_pc"}, 32'(halt_pc), 32'd0);
                check({tag, "_mode_latch"}, 32'(cpu_mode), 32'(v.mode));
                mode_sel = ~v.mode;
            end
            if (busy && cpu_reset) armc++;
            if (busy && !cpu_reset) begin
                k++;
                drive_core(k, v.halt_at, v.prev_pc);
            end else begin
                drive_idle();
            end
            if (seen_busy && (done || timeout)) ended = 1;
        end
        check({tag, "_finished_in_bound"}, 32'(ended), 32'd1);
        check({tag, "_done"}, 32'(done), 32'(v.exp_done));
        check({tag, "_timeout"}, 32'(timeout), 32'(v.exp_timeout));
        check({tag, "_run_cycles"}, run_cycles, v.exp_cycles);
        check({tag, "_halt_pc"}, 32'(halt_pc), 32'(v.exp_halt_pc));
        check({tag, "_cpu_mode"}, 32'(cpu_mode), 32'(v.mode));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(v.exp_timeout));
        check({tag, "_counter_enable"}, 32'(counter_enable), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_arm_cycles"}, 32'(armc), 32'd3);
        check({tag, "_released_cycles"}, 32'(k), v.exp_cycles);
    endtask

    initial begin
        int  arm_entries;
        bit  prev_busy;
        bit  early_busy;
        bit  got;
        int  k;

        vecs[0] = '{1'b1, 20, 16'h0013, 1'b1, 1'b0, 32'd25, 16'h0013};
        vecs[1] = '{1'b0,  0, 16'h0000, 1'b0, 1'b1, 32'd64, 16'h0000};
        vecs[2] = '{1'b1,  1, 16'h0000, 1'b0, 1'b1, 32'd64, 16'h0000};
        vecs[3] = '{1'b0,  2, 16'h00A5, 1'b1, 1'b0, 32'd7,  16'h00A5};
        vecs[4] = '{1'b1, 64, 16'hBEEF, 1'b1, 1'b0, 32'd69, 16'hBEEF};
        vecs[5] = '{1'b0, 63, 16'h1234, 1'b1, 1'b0, 32'd68, 16'h1234};

        // Reset state
        reset = 1'b1; start_btn = 1'b0; mode_sel = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_cpu_mode", 32'(cpu_mode), 32'd0);
        check("rst_counter_enable", 32'(counter_enable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_run_cycles", run_cycles, 32'd0);
        check("rst_halt_pc", 32'(halt_pc), 32'd0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        reset = 1'b0;

        // Bouncing button must not start a run
        early_busy = 0;
        for (int i = 0; i < 20; i++) begin
            start_btn = ((i / 2) % 2 == 0);
            @(negedge clk);
            if (busy) early_busy = 1;
        end
        start_btn = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (busy) early_busy = 1;
        end
        check("bounce_no_arm", 32'(early_busy), 32'd0);

        // Clean 10-cycle press: exactly one ARM entry
        arm_entries = 0; prev_busy = 0;
        for (int i = 0; i < 40; i++) begin
            start_btn = (i < 10);
            @(negedge clk);
            if (busy && !prev_busy) arm_entries++;
            prev_busy = busy;
        end
        check("held_one_arm", 32'(arm_entries), 32'd1);
        got = 0;
        for (int i = 0; i < 150 && !got; i++) begin
            @(negedge clk);
            if (timeout) got = 1;
        end
        check("held_run_timeout", 32'(got), 32'd1);

        // Full runs, each started from the previous DONE/TIMEOUT
        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Reset on the 7th RUN cycle
        start_btn = 1'b1;
        got = 0; k = 0;
        for (int i = 0; i < 60 && k < 7; i++) begin
            @(negedge clk);
            if (busy) start_btn = 1'b0;
            if (busy && !cpu_reset) k++;
        end
        check("rstmid_reached_run7", 32'(k), 32'd7);
        check("rstmid_cycles_before", run_cycles, 32'd6);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstmid_state", 32'(dut.state), 32'(IDLE));
        check("rstmid_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rstmid_run_cycles", run_cycles, 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_counter_enable", 32'(counter_enable), 32'd0);

        // Start pressed during RUN is ignored
        repeat (8) @(negedge clk);
        start_btn = 1'b1;
        k = 0;
        for (int i = 0; i < 80 && k < 20; i++) begin
            @(negedge clk);
            if (busy && cpu_reset && k == 0) start_btn = 1'b0;
            if (busy && !cpu_reset) begin
                k++;
                if (k == 6) start_btn = 1'b1;
            end
        end
        check("ign_reached_run20", 32'(k), 32'd20);
        check("ign_still_running", 32'({busy, cpu_reset}), 32'b10);
        check("ign_run_cycles", run_cycles, 32'd19);

        // Held button across reset must re-qualify through the debouncer
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        early_busy = 0;
        repeat (5) begin
            @(negedge clk);
            if (busy) early_busy = 1;
        end
        check("held_reset_no_early_arm", 32'(early_busy), 32'd0);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (busy) got = 1;
        end
        check("held_reset_requalify", 32'(got), 32'd1);
        start_btn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
